// File: rtl/ifetch_prefetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response port and decode port.
// All handshakes are strict valid/ready: a transfer happens on the cycle where both
// valid and ready are high; the consumer may not assume valid stays up without ready.
interface ifetch_prefetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [DATA_W-1:0] imem_resp_data;
  logic              dec_valid;
  logic              dec_ready;
  logic [DATA_W-1:0] dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic [ADDR_W-1:0] dec_link;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output dec_valid, dec_instr, dec_pc, dec_link,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  dec_valid, dec_instr, dec_pc, dec_link,
    output dec_ready
  );
endinterface

// File: rtl/ifetch_prefetch_unit.sv
// Instruction prefetch unit: credit-limited in-order fetch into a DEPTH-entry FIFO,
// with redirect flush and drop accounting for stale in-flight responses.
module ifetch_prefetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  ifetch_prefetch_unit_if.master     bus,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic [$clog2(DEPTH):0]     drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc;

  logic [ADDR_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0]  tag_wr;
  logic [PTR_W-1:0]  tag_rd;

  logic [ADDR_W-1:0] fifo_pc    [DEPTH];
  logic [DATA_W-1:0] fifo_instr [DEPTH];
  logic [PTR_W-1:0]  fifo_wr;
  logic [PTR_W-1:0]  fifo_rd;
  logic [CNT_W-1:0]  fifo_count;

  logic [CNT_W:0]    credit_used;
  logic              accept;
  logic              resp_ok;
  logic              push;
  logic              pop;

  // Dropped-but-outstanding requests still hold a credit, so a late response
  // can never find the FIFO full.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};

  assign bus.imem_req_valid = !rst && fetch_en && !redirect &&
                              (credit_used < (CNT_W+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;

  assign accept  = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_ok = bus.imem_resp_valid && (inflight != '0);
  assign push    = resp_ok && !redirect && (drop_cnt == '0);
  assign pop     = bus.dec_valid && bus.dec_ready && !redirect;

  assign bus.dec_valid = (fifo_count != '0);
  assign bus.dec_pc    = fifo_pc[fifo_rd];
  assign bus.dec_instr = fifo_instr[fifo_rd];
  assign bus.dec_link  = fifo_pc[fifo_rd] + ADDR_W'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_pc & ~ADDR_W'(3);
      end else if (accept) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (accept) begin
        tag_wr <= tag_wr + PTR_W'(1);
      end
      // Dropped responses still retire their tag so the queue stays in order.
      if (resp_ok) begin
        tag_rd <= tag_rd + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(accept) - CNT_W'(resp_ok);
      // On redirect every request still outstanding after this cycle is stale.
      if (redirect) begin
        drop_cnt <= inflight - CNT_W'(resp_ok);
      end else if (resp_ok && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_wr <= fifo_wr + PTR_W'(1);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + PTR_W'(1);
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[fifo_wr]    <= tag_mem[tag_rd];
      fifo_instr[fifo_wr] <= bus.imem_resp_data;
    end
  end

endmodule
